// File: rtl/yags_pkg.sv
// Shared types for the YAGS resolver: metadata captured at fetch and the update command.
// Latency: none (types, constants and a pure combinational helper only).
// Backpressure: not applicable.
package yags_pkg;

    localparam int PC_W    = 10;
    localparam int GHR_W   = 10;
    localparam int TAG_W   = 9;
    localparam int Q_DEPTH = 4;

    localparam logic CACHE_NT = 1'b0;
    localparam logic CACHE_T  = 1'b1;

    // Everything needed at EX to train the predictor without re-reading its tables.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] idx;
        logic            choice;
        logic            hit;
        logic            cache_pred;
        logic            final_pred;
    } yags_meta_t;

    typedef struct packed {
        logic             valid;
        logic             choice_en;
        logic [PC_W-1:0]  choice_idx;
        logic             cache_en;
        logic             cache_sel;
        logic             cache_alloc;
        logic [PC_W-1:0]  cache_idx;
        logic [TAG_W-1:0] cache_tag;
        logic             taken;
        logic             mispredict;
    } yags_upd_t;

    // Training decision for one resolved branch.
    function automatic yags_upd_t yags_resolve(input yags_meta_t m, input logic taken);
        yags_upd_t u;
        u             = '0;
        u.valid       = 1'b1;
        u.taken       = taken;
        u.mispredict  = (m.final_pred != taken);
        // A cache hit that was right while the choice was wrong must not disturb the choice PHT.
        u.choice_en   = !(m.hit && (m.cache_pred == taken) && (m.choice != taken));
        u.choice_idx  = m.pc;
        // A taken choice consulted the NT cache, so that is the one trained.
        u.cache_sel   = m.choice ? CACHE_NT : CACHE_T;
        u.cache_en    = m.hit || (m.choice != taken);
        u.cache_alloc = !m.hit && (m.choice != taken);
        u.cache_idx   = m.idx;
        u.cache_tag   = m.pc[TAG_W-1:0];
        return u;
    endfunction

endpackage

// File: rtl/yags_branch_resolver_if.sv
// Fetch/EX/update bundle between the pipeline (master) and the resolver (slave).
// Latency: none (wiring only).
// Backpressure: fetch_stall is the only flow-control signal, driven by the slave.
interface yags_branch_resolver_if;
    import yags_pkg::*;

    logic             fetch_branch;
    logic [PC_W-1:0]  fetch_pc;
    logic             fetch_choice_pred;
    logic             fetch_cache_hit;
    logic             fetch_cache_pred;
    logic             fetch_stall;
    logic [GHR_W-1:0] ghr_spec;

    logic             ex_valid;
    logic             ex_taken;
    logic             ex_flush;

    logic             upd_valid;
    logic             upd_choice_en;
    logic [PC_W-1:0]  upd_choice_idx;
    logic             upd_cache_en;
    logic             upd_cache_sel;
    logic             upd_cache_alloc;
    logic [PC_W-1:0]  upd_cache_idx;
    logic [TAG_W-1:0] upd_cache_tag;
    logic             upd_taken;
    logic             mispredict;
    logic             q_underflow;

    modport master (
        output fetch_branch, fetch_pc, fetch_choice_pred, fetch_cache_hit, fetch_cache_pred,
        output ex_valid, ex_taken, ex_flush,
        input  fetch_stall, ghr_spec,
        input  upd_valid, upd_choice_en, upd_choice_idx, upd_cache_en, upd_cache_sel,
        input  upd_cache_alloc, upd_cache_idx, upd_cache_tag, upd_taken, mispredict, q_underflow
    );

    modport slave (
        input  fetch_branch, fetch_pc, fetch_choice_pred, fetch_cache_hit, fetch_cache_pred,
        input  ex_valid, ex_taken, ex_flush,
        output fetch_stall, ghr_spec,
        output upd_valid, upd_choice_en, upd_choice_idx, upd_cache_en, upd_cache_sel,
        output upd_cache_alloc, upd_cache_idx, upd_cache_tag, upd_taken, mispredict, q_underflow
    );

endinterface

// File: rtl/yags_meta_fifo.sv
// In-order queue of in-flight branch metadata with flush and same-cycle push/pop.
// Latency: head is combinational from storage; a push is visible at the head one cycle later.
// Backpressure: full/empty reported; caller gates push/pop (push on full is legal with a pop).
module yags_meta_fifo
    import yags_pkg::*;
#(
    parameter int DEPTH = Q_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  yags_meta_t wr_dat,
    output yags_meta_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    yags_meta_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards all entries at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents need no reset since occupancy says what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/yags_branch_resolver.sv
// YAGS resolver: queues fetch metadata, issues predictor update at EX, owns spec/committed GHR.
// Latency: update command registered, one cycle after ex_valid; ghr_spec updates on the same edge.
// Backpressure: fetch_stall = fetch_branch & full; optional YAGS_STATS_EN adds saturating stat counters.
module yags_branch_resolver
    import yags_pkg::*;
#(
    parameter int PC_size  = PC_W,
    parameter int GHR_size = GHR_W,
    parameter int Tag_size = TAG_W,
    parameter int DEPTH    = Q_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    yags_branch_resolver_if.slave  bus
`ifdef YAGS_STATS_EN
    ,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispredicts
`endif
);

    logic [GHR_size-1:0] ghr_spec;
    logic [GHR_size-1:0] ghr_commit;
    logic [GHR_size-1:0] ghr_commit_nxt;
    logic                final_pred;
    logic                full;
    logic                empty;
    logic                do_pop;
    logic                do_push;
    logic                mis_now;
    logic                flush_ex;
    logic                flush;
    logic                q_underflow;
    yags_meta_t          wr_dat;
    yags_meta_t          head;
    yags_upd_t           cmd;
    yags_upd_t           upd_q;

    assign final_pred     = bus.fetch_cache_hit ? bus.fetch_cache_pred : bus.fetch_choice_pred;
    assign do_pop         = bus.ex_valid && !empty;
    assign cmd            = yags_resolve(head, bus.ex_taken);
    assign mis_now        = do_pop && cmd.mispredict;
    assign flush_ex       = bus.ex_flush && !bus.ex_valid;
    // Anything fetched alongside a redirect is wrong-path and is discarded.
    assign flush          = mis_now || flush_ex;
    assign do_push        = bus.fetch_branch && !flush && (!full || do_pop);
    assign ghr_commit_nxt = {ghr_commit[GHR_size-2:0], bus.ex_taken};

    assign wr_dat.pc         = bus.fetch_pc;
    assign wr_dat.idx        = bus.fetch_pc ^ PC_size'(ghr_spec);
    assign wr_dat.choice     = bus.fetch_choice_pred;
    assign wr_dat.hit        = bus.fetch_cache_hit;
    assign wr_dat.cache_pred = bus.fetch_cache_pred;
    assign wr_dat.final_pred = final_pred;

    yags_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (do_push),
        .pop    (do_pop),
        .flush  (flush),
        .wr_dat (wr_dat),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    // History: committed follows resolved outcomes, speculative follows predictions or recovers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
        end else begin
            if (do_pop) ghr_commit <= ghr_commit_nxt;
            if (mis_now)       ghr_spec <= ghr_commit_nxt;
            else if (flush_ex) ghr_spec <= ghr_commit;
            else if (do_push)  ghr_spec <= {ghr_spec[GHR_size-2:0], final_pred};
        end
    end

    // Registered update command, a one-cycle pulse per resolved branch; underflow is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_q       <= '0;
            q_underflow <= 1'b0;
        end else begin
            upd_q <= do_pop ? cmd : '0;
            if (bus.ex_valid && empty) q_underflow <= 1'b1;
        end
    end

`ifdef YAGS_STATS_EN
    // Saturating resolved-branch and mispredict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_pop && (stat_branches != '1))     stat_branches    <= stat_branches + 1'b1;
            if (mis_now && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`endif

    assign bus.fetch_stall     = bus.fetch_branch && full;
    assign bus.ghr_spec        = ghr_spec;
    assign bus.upd_valid       = upd_q.valid;
    assign bus.upd_choice_en   = upd_q.choice_en;
    assign bus.upd_choice_idx  = upd_q.choice_idx;
    assign bus.upd_cache_en    = upd_q.cache_en;
    assign bus.upd_cache_sel   = upd_q.cache_sel;
    assign bus.upd_cache_alloc = upd_q.cache_alloc;
    assign bus.upd_cache_idx   = upd_q.cache_idx;
    assign bus.upd_cache_tag   = upd_q.cache_tag[Tag_size-1:0];
    assign bus.upd_taken       = upd_q.taken;
    assign bus.mispredict      = upd_q.mispredict;
    assign bus.q_underflow     = q_underflow;

endmodule

// File: tb/tb_yags_branch_resolver.sv
// Bench for yags_branch_resolver: directed scenarios plus random traffic against a queue-based model.
// Latency: expects update outputs one cycle after ex_valid, fetch_stall combinational.
// Backpressure: model drops pushes when the queue holds DEPTH entries and nothing leaves.
module tb_yags_branch_resolver;
    import yags_pkg::*;

    localparam int DEPTH = 4;
    localparam int MASK  = (1 << GHR_W) - 1;

    typedef struct {
        int pc;
        int idx;
        bit choice;
        bit hit;
        bit cpred;
        bit fin;
    } m_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    yags_branch_resolver_if bus();

`ifdef YAGS_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    yags_branch_resolver #(
        .PC_size(PC_W), .GHR_size(GHR_W), .Tag_size(TAG_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef YAGS_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    m_t q[$];
    int ghr_s, ghr_c;
    bit uf;
    int st_b, st_m;
    bit e_vld, e_mis, e_cen, e_csel, e_calloc, e_chen, e_taken;
    int e_cidx, e_chidx, e_tag;
    bit stall_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit fb, input int pc, input bit ch, input bit hit,
                         input bit cp, input bit exv, input bit ext, input bit exf);
        m_t h, n;
        bit pop, mis, fl, psh, fin;
        int gc_new, size0;
        rst                   = r;
        bus.fetch_branch      = fb;
        bus.fetch_pc          = PC_W'(pc);
        bus.fetch_choice_pred = ch;
        bus.fetch_cache_hit   = hit;
        bus.fetch_cache_pred  = cp;
        bus.ex_valid          = exv;
        bus.ex_taken          = ext;
        bus.ex_flush          = exf;
        #1;
        stall_seen = bus.fetch_stall;
        chk("fetch_stall", int'(bus.fetch_stall), (fb && q.size() == DEPTH) ? 1 : 0);

        e_vld = 0; e_mis = 0; e_cen = 0; e_csel = 0; e_calloc = 0; e_chen = 0; e_taken = 0;
        e_cidx = 0; e_chidx = 0; e_tag = 0;
        if (r) begin
            q.delete();
            ghr_s = 0; ghr_c = 0; uf = 0; st_b = 0; st_m = 0;
        end else begin
            size0  = q.size();
            pop    = exv && size0 > 0;
            mis    = 0;
            gc_new = ghr_c;
            if (exv && size0 == 0) uf = 1;
            if (pop) begin
                h       = q.pop_front();
                mis     = (h.fin != ext);
                e_vld   = 1;
                e_mis   = mis;
                e_taken = ext;
                e_chidx = h.pc;
                e_cidx  = h.idx;
                e_tag   = h.pc % 512;
                e_csel  = !h.choice;
                e_chen  = !(h.hit && h.cpred == ext && h.choice != ext);
                if (h.hit) begin
                    e_cen = 1; e_calloc = 0;
                end else if (h.choice != ext) begin
                    e_cen = 1; e_calloc = 1;
                end else begin
                    e_cen = 0;
                end
                gc_new = ((ghr_c * 2) + int'(ext)) & MASK;
                st_b++;
                if (mis) st_m++;
            end
            fl  = mis || (exf && !exv);
            psh = fb && !fl && (size0 < DEPTH || pop);
            fin = hit ? cp : ch;
            if (fl) q.delete();
            if (mis) ghr_s = gc_new;
            else if (exf && !exv) ghr_s = ghr_c;
            else if (psh) begin
                n.pc = pc; n.idx = pc ^ ghr_s; n.choice = ch; n.hit = hit; n.cpred = cp; n.fin = fin;
                q.push_back(n);
                ghr_s = ((ghr_s * 2) + int'(fin)) & MASK;
            end
            ghr_c = gc_new;
        end

        @(posedge clk);
        #1;
        chk("upd_valid", int'(bus.upd_valid), int'(e_vld));
        chk("ghr_spec", int'(bus.ghr_spec), ghr_s);
        chk("q_underflow", int'(bus.q_underflow), int'(uf));
        if (e_vld) begin
            chk("mispredict", int'(bus.mispredict), int'(e_mis));
            chk("upd_taken", int'(bus.upd_taken), int'(e_taken));
            chk("upd_choice_en", int'(bus.upd_choice_en), int'(e_chen));
            chk("upd_choice_idx", int'(bus.upd_choice_idx), e_chidx);
            chk("upd_cache_en", int'(bus.upd_cache_en), int'(e_cen));
            chk("upd_cache_sel", int'(bus.upd_cache_sel), int'(e_csel));
            if (e_cen) chk("upd_cache_alloc", int'(bus.upd_cache_alloc), int'(e_calloc));
            chk("upd_cache_idx", int'(bus.upd_cache_idx), e_cidx);
            chk("upd_cache_tag", int'(bus.upd_cache_tag), e_tag);
        end
`ifdef YAGS_STATS_EN
        chk("stat_branches", int'(stat_branches), st_b);
        chk("stat_mispredicts", int'(stat_mispredicts), st_m);
`endif
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit exv, exf, r;
        // Reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ghr", int'(bus.ghr_spec), 0);
        chk("rst_upd_valid", int'(bus.upd_valid), 0);
        chk("rst_underflow", int'(bus.q_underflow), 0);

        // Push pc=0x3A5 with empty history, predicted taken; resolve correctly
        cycle(0, 1, 'h3A5, 1, 0, 0, 0, 0, 0);
        chk("t1_ghr", int'(bus.ghr_spec), 'h001);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t1_idx", int'(bus.upd_cache_idx), 'h3A5);
        chk("t1_tag", int'(bus.upd_cache_tag), 'h1A5);
        chk("t1_mis", int'(bus.mispredict), 0);

        // Choice taken, miss, actual not-taken -> allocate in NT cache
        cycle(0, 1, 'h155, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t2_vld", int'(bus.upd_valid), 1);
        chk("t2_mis", int'(bus.mispredict), 1);
        chk("t2_cen", int'(bus.upd_cache_en), 1);
        chk("t2_sel", int'(bus.upd_cache_sel), 0);
        chk("t2_alloc", int'(bus.upd_cache_alloc), 1);
        chk("t2_chen", int'(bus.upd_choice_en), 1);
        chk("t2_ghr", int'(bus.ghr_spec), 'h002);

        // Choice not-taken, T cache hit predicting taken, actual taken
        cycle(0, 1, 'h0F0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t3_chen", int'(bus.upd_choice_en), 0);
        chk("t3_cen", int'(bus.upd_cache_en), 1);
        chk("t3_sel", int'(bus.upd_cache_sel), 1);
        chk("t3_alloc", int'(bus.upd_cache_alloc), 0);
        chk("t3_mis", int'(bus.mispredict), 0);

        // Fill the queue, stall on the fifth, then push alongside a correct pop
        for (int i = 0; i < 4; i++) cycle(0, 1, 37 * i + 5, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 'h200, 1, 0, 0, 0, 0, 0);
        chk("t4_stall", int'(stall_seen), 1);
        cycle(0, 1, 'h200, 1, 0, 0, 1, 1, 0);
        chk("t4_pop_vld", int'(bus.upd_valid), 1);
        cycle(0, 1, 'h201, 1, 0, 0, 0, 0, 0);
        chk("t4_still_full", int'(stall_seen), 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t4_ghr", int'(bus.ghr_spec), 'h0BF);

        // Mispredict with a coincident fetch: the new branch is dropped
        cycle(0, 1, 'h011, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 'h022, 1, 0, 0, 1, 0, 0);
        chk("t6_mis", int'(bus.mispredict), 1);
        chk("t6_ghr", int'(bus.ghr_spec), 'h17E);

        // Resolve on an empty queue: no command, sticky underflow
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5_vld", int'(bus.upd_valid), 0);
        chk("t5_uf", int'(bus.q_underflow), 1);
        idle();
        chk("t5_uf_sticky", int'(bus.q_underflow), 1);

        // Pipeline flush restores committed history and empties the queue
        cycle(0, 1, 'h033, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 'h044, 1, 0, 0, 0, 0, 0);
        chk("t6_ghr_spec", int'(bus.ghr_spec), 'h1FB);
        cycle(0, 1, 'h055, 1, 0, 0, 0, 0, 1);
        chk("t6_flush_ghr", int'(bus.ghr_spec), 'h17E);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t6_flushed_empty", int'(bus.upd_valid), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            exv = ($urandom_range(0, 99) < 35);
            exf = !exv && ($urandom_range(0, 99) < 5);
            cycle(r, !r && ($urandom_range(0, 1) == 1), int'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  !r && exv, 1'($urandom_range(0, 1)), !r && exf);
        end

        // Final reset clears the sticky flag and history
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("end_rst_uf", int'(bus.q_underflow), 0);
        chk("end_rst_ghr", int'(bus.ghr_spec), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yags_branch_resolver.md
Name: yags_branch_resolver

Overview:
- Resolution end of the YAGS predictor interface.
- Captures per-branch prediction metadata at fetch and holds it in an in-order in-flight queue.
- At EX, compares the actual outcome against the captured metadata and issues one registered update command to the choice PHT and the taken/not-taken exception caches.
- Owns the speculative and committed GHR, including mispredict recovery.

Parameters:
- PC_size, 10, PC bits used for index and tag.
- GHR_size, 10, global history length.
- Tag_size, 9, exception-cache tag width.
- DEPTH, 4, in-flight branch queue entries (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- fetch_branch  in  1  branch present in fetch this cycle.
- fetch_pc  in  PC_size  fetch PC.
- fetch_choice_pred  in  1  choice PHT prediction (1 = taken, so the NT cache is consulted).
- fetch_cache_hit  in  1  hit in the consulted cache.
- fetch_cache_pred  in  1  consulted cache's prediction.
- fetch_stall  out  1  queue full while fetch_branch is high.
- ghr_spec  out  GHR_size  speculative history for fetch indexing.
- ex_valid  in  1  branch resolved in EX.
- ex_taken  in  1  actual outcome.
- ex_flush  in  1  non-branch pipeline flush.
- upd_valid  out  1  update command pulse.
- upd_choice_en  out  1  choice PHT is to be trained.
- upd_choice_idx  out  PC_size  choice PHT index (PC).
- upd_cache_en  out  1  exception cache write.
- upd_cache_sel  out  1  0 = NT cache, 1 = T cache.
- upd_cache_alloc  out  1  1 = allocate new entry, 0 = update hit entry.
- upd_cache_idx  out  PC_size  PC ^ GHR captured at fetch.
- upd_cache_tag  out  Tag_size  PC[Tag_size-1:0].
- upd_taken  out  1  outcome to train with.
- mispredict  out  1  final prediction was wrong.
- q_underflow  out  1  sticky error flag.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, ports clk and rst. While rst=1, at the clock edge:
  - queue is emptied;
  - ghr_spec and committed GHR are cleared to 0;
  - all outputs go to 0.
- Final prediction at fetch is computed internally:
  - fetch_cache_hit=1: final = fetch_cache_pred;
  - fetch_cache_hit=0: final = fetch_choice_pred.
- Push: occurs when fetch_branch=1 and the queue is not full.
  - Stores pc, idx = pc ^ ghr_spec, choice, hit, cache_pred, final.
  - ghr_spec <= {ghr_spec[GHR_size-2:0], final}.
- Full queue:
  - fetch_stall = fetch_branch & full (combinational).
  - The push is suppressed; fetch holds and retries.
- Pop: occurs when ex_valid=1; the head entry resolves.
- Command outputs are registered and appear the cycle after ex_valid (latency 1). upd_valid is high for exactly one cycle.
- Command fields:
  - mispredict = final != ex_taken.
  - upd_choice_en = 0 only when hit=1, cache_pred==ex_taken and choice!=ex_taken; otherwise 1.
  - Cache select: upd_cache_sel = !choice (taken choice selects the NT cache, sel 0).
  - Hit case: upd_cache_en=1, upd_cache_alloc=0.
  - Miss case, choice!=ex_taken: upd_cache_en=1, upd_cache_alloc=1.
  - Miss case, choice==ex_taken: upd_cache_en=0.
- Committed GHR shifts in ex_taken on every pop.
- Mispredict recovery:
  - Queue is flushed.
  - ghr_spec <= committed GHR shifted with ex_taken, in the same edge as the pop.
- ex_flush=1 without ex_valid:
  - Queue is flushed.
  - ghr_spec <= committed GHR.
- Simultaneous events:
  - Push and pop in the same cycle: both happen and count is unchanged. Pushing when full is allowed if a non-mispredicting pop frees an entry that cycle.
  - Mispredict or ex_flush coincident with a push: the flush wins and the push is dropped as wrong-path.
- Boundaries:
  - ex_valid on an empty queue: no command is issued and q_underflow is set (sticky until rst).
  - Pointers wrap modulo DEPTH.
  - Count is DEPTH+1 states wide.

Optional Feature:
- Macro YAGS_STATS_EN.
- When defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0]. Both are saturating counters, incremented on each valid pop and each mispredict, and cleared on rst.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package yags_pkg holds:
  - typedef yags_meta_t (pc, idx, choice, hit, cache_pred, final);
  - typedef yags_upd_t (the command fields);
  - localparams CACHE_NT=0, CACHE_T=1.
- One sub-module, yags_meta_fifo: a synchronous DEPTH-entry queue of yags_meta_t with push, pop, flush, full, empty and same-cycle push/pop support.

Test Plan:
1. Reset, then push pc=0x3A5 with ghr_spec=0, final=1 -> stored idx=0x3A5, ghr_spec=0x001.
2. Push choice=1 hit=0; ex_taken=0 -> next cycle: upd_valid=1, mispredict=1, upd_cache_en=1, sel=0, alloc=1, upd_choice_en=1, queue empty, ghr_spec=committed<<1|0.
3. Push choice=0 hit=1 cache_pred=1; ex_taken=1 -> upd_choice_en=0, upd_cache_en=1, sel=1, alloc=0, mispredict=0.
4. Push 4 branches with DEPTH=4, then a fifth -> fetch_stall=1, no push. Then a correct-prediction pop coincident with the fifth push -> push accepted, count stays 4.
5. ex_valid with the queue empty -> upd_valid stays 0 and q_underflow=1 until rst.
6. Mispredict coincident with fetch_branch -> the new branch is dropped (queue empty next cycle). Separately, ex_flush -> ghr_spec equals committed GHR.
